// File: rtl/carus_sram_arbiter.sv
// Two-port OBI-style arbiter in front of a single-port 32-bit SRAM, with
// idle-driven retention entry and a fixed-length wake stall before re-granting.
//
// state     | meaning
// ACTIVE    | SRAM powered, requests granted round-robin in the address phase
// RETENTIVE | SRAM in retention, requests stalled until one is seen
// WAKE      | leaving retention, requests stalled for WAKE_CYCLES cycles
module carus_sram_arbiter #(
    parameter int unsigned NUM_WORDS       = 1024,
    parameter int unsigned RET_IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES     = 2,
    localparam int unsigned AddrWidth      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 p0_req_i,
    input  logic                 p0_we_i,
    input  logic [AddrWidth-1:0] p0_addr_i,
    input  logic [31:0]          p0_wdata_i,
    input  logic [3:0]           p0_be_i,
    output logic                 p0_gnt_o,
    output logic                 p0_rvalid_o,
    output logic [31:0]          p0_rdata_o,

    input  logic                 p1_req_i,
    input  logic                 p1_we_i,
    input  logic [AddrWidth-1:0] p1_addr_i,
    input  logic [31:0]          p1_wdata_i,
    input  logic [3:0]           p1_be_i,
    output logic                 p1_gnt_o,
    output logic                 p1_rvalid_o,
    output logic [31:0]          p1_rdata_o,

    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_be_o,
    input  logic [31:0]          mem_rdata_i,
    output logic                 mem_set_retentive_no
);

    localparam int unsigned IdleW = (RET_IDLE_CYCLES > 0) ? $clog2(RET_IDLE_CYCLES + 1) : 1;
    localparam logic [IdleW-1:0] IdleThr  = IdleW'(RET_IDLE_CYCLES);
    localparam logic [IdleW-1:0] IdleMax  = '1;
    localparam logic [3:0]       WakeLast = 4'(WAKE_CYCLES - 1);
    localparam bit               RetEn    = (RET_IDLE_CYCLES != 0);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_RET    = 2'd1;
    localparam logic [1:0] ST_WAKE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [3:0]       wake_q, wake_d;
    logic             last_q, last_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0]       rd_q, rd_d;

    logic any_req;
    logic gnt0, gnt1;
    logic idle_cond;

    assign any_req = p0_req_i | p1_req_i;

    // last_q == 1 means port 1 was granted last, so port 0 wins a conflict
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_ni && state_q == ST_ACTIVE) begin
            gnt0 = p0_req_i & (~p1_req_i | last_q);
            gnt1 = p1_req_i & (~p0_req_i | ~last_q);
        end
    end

    assign idle_cond = (state_q == ST_ACTIVE) && !any_req && (rvalid_q == 2'b00);

    always_comb begin
        state_d = state_q;
        idle_d  = '0;
        wake_d  = '0;
        case (state_q)
            ST_ACTIVE: begin
                if (idle_cond) begin
                    if (RetEn && idle_q == IdleThr) begin
                        state_d = ST_RET;
                    end else begin
                        idle_d = (idle_q == IdleMax) ? idle_q : idle_q + 1'b1;
                    end
                end
            end
            ST_RET: begin
                if (any_req) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (wake_q == WakeLast) begin
                    state_d = ST_ACTIVE;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_comb begin
        last_d   = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_q);
        rvalid_d = {gnt1, gnt0};
        rd_d     = {gnt1 & ~p1_we_i, gnt0 & ~p0_we_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_ACTIVE;
            idle_q   <= '0;
            wake_q   <= '0;
            last_q   <= 1'b1;
            rvalid_q <= 2'b00;
            rd_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            wake_q   <= wake_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        mem_req_o   = gnt0 | gnt1;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = 4'h0;
        if (gnt1) begin
            mem_we_o    = p1_we_i;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
            mem_be_o    = p1_we_i ? p1_be_i : 4'hF;
        end else if (gnt0) begin
            mem_we_o    = p0_we_i;
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
            mem_be_o    = p0_we_i ? p0_be_i : 4'hF;
        end
    end

    assign p0_gnt_o    = gnt0;
    assign p1_gnt_o    = gnt1;
    assign p0_rvalid_o = rvalid_q[0];
    assign p1_rvalid_o = rvalid_q[1];
    assign p0_rdata_o  = (rvalid_q[0] && rd_q[0]) ? mem_rdata_i : 32'h0;
    assign p1_rdata_o  = (rvalid_q[1] && rd_q[1]) ? mem_rdata_i : 32'h0;

    assign mem_set_retentive_no = (state_q != ST_RET);

endmodule
